// File: rtl/multi_lane_stage_queue_if.sv
// Handshake bundle for multi_lane_stage_queue: per-lane enqueue and dequeue lanes.
// The producer/consumer side uses master; the queue uses slave.
interface multi_lane_stage_queue_if #(
  parameter int WIDTH  = 2,
  parameter int DATA_W = 96
);
  logic [WIDTH-1:0]        enq_valid;
  logic [WIDTH*DATA_W-1:0] enq_data;
  logic                    enq_ready;
  logic [WIDTH-1:0]        deq_valid;
  logic [WIDTH*DATA_W-1:0] deq_data;
  logic [WIDTH-1:0]        deq_take;

  modport master (
    output enq_valid, enq_data, deq_take,
    input  enq_ready, deq_valid, deq_data
  );

  modport slave (
    input  enq_valid, enq_data, deq_take,
    output enq_ready, deq_valid, deq_data
  );
endinterface

// File: rtl/multi_lane_stage_queue.sv
// N-lane in-order buffer between pipeline stages, with compacting enqueue and prefix dequeue.
// Define QUEUE_STATS_EN to build the high-water-mark and drop counters.
module multi_lane_stage_queue #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 96
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  multi_lane_stage_queue_if.slave  q,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   hwm,
  output logic [15:0]              drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     free;
  logic [CW-1:0]     n_enq;
  logic [CW-1:0]     n_deq;
  logic [CW-1:0]     count_next;
  logic [CW-1:0]     offset [WIDTH];
  logic              enq_fire;
  logic              run;

  // Readiness looks only at registered occupancy; same-cycle dequeues do not free room.
  assign free        = CW'(DEPTH) - count;
  assign q.enq_ready = free >= CW'(WIDTH);
  assign enq_fire    = q.enq_ready & (|q.enq_valid);

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < WIDTH; i++) begin
      offset[i] = n_enq;
      if (q.enq_valid[i]) n_enq = n_enq + CW'(1);
    end
  end

  always_comb begin
    n_deq = '0;
    run   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (run && q.deq_take[i] && q.deq_valid[i]) n_deq = n_deq + CW'(1);
      else run = 1'b0;
    end
  end

  assign count_next = flush ? '0 : count + (enq_fire ? n_enq : '0) - n_deq;

  for (genvar g = 0; g < WIDTH; g++) begin : g_deq
    assign q.deq_valid[g]                   = count > CW'(g);
    assign q.deq_data[g*DATA_W +: DATA_W]   = mem[head + PW'(g)];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      count <= count_next;
      head  <= head + n_deq[PW-1:0];
      if (enq_fire) tail <= tail + n_enq[PW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire && !flush) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (q.enq_valid[i]) mem[tail + offset[i][PW-1:0]] <= q.enq_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef QUEUE_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hwm      <= '0;
      drop_cnt <= '0;
    end else begin
      if (count_next > hwm) hwm <= count_next;
      if ((|q.enq_valid) && !q.enq_ready && !flush && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign hwm      = '0;
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_multi_lane_stage_queue.sv
// Directed and random scoreboard bench for multi_lane_stage_queue (WIDTH=2, DEPTH=8, DATA_W=96).
module tb_multi_lane_stage_queue;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  count;
  logic [3:0]  hwm;
  logic [15:0] drop_cnt;

  multi_lane_stage_queue_if #(.WIDTH(2), .DATA_W(96)) q();

  multi_lane_stage_queue #(.WIDTH(2), .DEPTH(8), .DATA_W(96)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .q(q),
    .count(count), .hwm(hwm), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [95:0] sb[$];
  int          m_count = 0;
  int          m_hwm = 0;
  int          m_drop = 0;
  int          tag_n = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] mk();
    tag_n++;
    return {64'hF00D_0000_0000_0000 + 64'(tag_n), 32'hC0DE_0000 + 32'(tag_n)};
  endfunction

  // Drive one cycle, compare outputs against the model, then advance the model across the edge.
  task automatic cyc(input logic [1:0] ev, input logic [95:0] d0, input logic [95:0] d1,
                     input logic [1:0] tk, input logic fl);
    logic       rdy;
    logic [1:0] dv;
    logic       run;
    int         nd;
    q.enq_valid = ev;
    q.enq_data  = {d1, d0};
    q.deq_take  = tk;
    flush       = fl;
    #1;
    rdy = (8 - m_count) >= 2;
    dv  = {m_count > 1, m_count > 0};
    chk("count", 128'(count), 128'(m_count));
    chk("enq_ready", 128'(q.enq_ready), 128'(rdy));
    chk("deq_valid", 128'(q.deq_valid), 128'(dv));
    chk("hwm", 128'(hwm), 128'(m_hwm));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    if (m_count > 0) chk("deq_lane0", 128'(q.deq_data[95:0]), 128'(sb[0]));
    if (m_count > 1) chk("deq_lane1", 128'(q.deq_data[191:96]), 128'(sb[1]));
    if (fl) begin
      sb.delete();
    end else begin
      nd  = 0;
      run = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (run && tk[i] && i < m_count) nd++;
        else run = 1'b0;
      end
      repeat (nd) void'(sb.pop_front());
      if (rdy && |ev) begin
        if (ev[0]) sb.push_back(d0);
        if (ev[1]) sb.push_back(d1);
      end
`ifdef QUEUE_STATS_EN
      if (|ev && !rdy && m_drop != 65535) m_drop++;
`endif
    end
    m_count = sb.size();
`ifdef QUEUE_STATS_EN
    if (m_count > m_hwm) m_hwm = m_count;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(2'b00, '0, '0, 2'b00, 1'b0);
  endtask

  initial begin
    logic [95:0] a, b, c, x, y, p;
    q.enq_valid = '0;
    q.enq_data  = '0;
    q.deq_take  = '0;
    #12 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Reset then idle.
    idle();
    idle();

    // Fill to 5, then asynchronous reset mid-operation.
    cyc(2'b11, mk(), mk(), 2'b00, 1'b0);
    cyc(2'b11, mk(), mk(), 2'b00, 1'b0);
    cyc(2'b01, mk(), mk(), 2'b00, 1'b0);
    chk("count_before_reset", 128'(count), 128'(5));
    q.enq_valid = '0;
    q.deq_take  = '0;
    resetn = 1'b0;
    #2;
    chk("count_async_reset", 128'(count), 128'(0));
    chk("enq_ready_async_reset", 128'(q.enq_ready), 128'(1));
    chk("hwm_async_reset", 128'(hwm), 128'(0));
    sb.delete();
    m_count = 0;
    m_hwm = 0;
    m_drop = 0;
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    idle();

    // Two-lane then sparse upper-lane enqueue, then full take.
    a = mk(); b = mk(); c = mk();
    cyc(2'b11, a, b, 2'b00, 1'b0);
    cyc(2'b10, '0, c, 2'b00, 1'b0);
    chk("lane0_is_A", 128'(q.deq_data[95:0]), 128'(a));
    chk("lane1_is_B", 128'(q.deq_data[191:96]), 128'(b));
    cyc(2'b00, '0, '0, 2'b11, 1'b0);
    chk("lane0_is_C", 128'(q.deq_data[95:0]), 128'(c));
    chk("count_after_take", 128'(count), 128'(1));

    // Fill to 7, rejected group with partial take.
    cyc(2'b11, mk(), mk(), 2'b00, 1'b0);
    cyc(2'b11, mk(), mk(), 2'b00, 1'b0);
    cyc(2'b11, mk(), mk(), 2'b00, 1'b0);
    chk("full7_not_ready", 128'(q.enq_ready), 128'(0));
    cyc(2'b11, mk(), mk(), 2'b01, 1'b0);
    chk("count_after_drop", 128'(count), 128'(6));
    chk("ready_after_drop", 128'(q.enq_ready), 128'(1));
`ifdef QUEUE_STATS_EN
    chk("drop_cnt_one", 128'(drop_cnt), 128'(1));
    chk("hwm_seven", 128'(hwm), 128'(7));
`endif

    // Drain, then move head and tail to slot 7 for the wrap case.
    repeat (3) cyc(2'b00, '0, '0, 2'b11, 1'b0);
    repeat (3) cyc(2'b11, mk(), mk(), 2'b00, 1'b0);
    repeat (3) cyc(2'b00, '0, '0, 2'b11, 1'b0);
    x = mk(); y = mk();
    cyc(2'b11, x, y, 2'b00, 1'b0);
    chk("wrap_lane0_X", 128'(q.deq_data[95:0]), 128'(x));
    chk("wrap_lane1_Y", 128'(q.deq_data[191:96]), 128'(y));
    cyc(2'b00, '0, '0, 2'b11, 1'b0);
    chk("wrap_drained", 128'(count), 128'(0));
    cyc(2'b11, mk(), mk(), 2'b00, 1'b0);

    // Non-prefix take is ignored; take beyond occupancy is ignored.
    cyc(2'b00, '0, '0, 2'b10, 1'b0);
    chk("nonprefix_count", 128'(count), 128'(2));
    cyc(2'b00, '0, '0, 2'b01, 1'b0);
    cyc(2'b00, '0, '0, 2'b11, 1'b0);
    idle();

    // Flush beats same-cycle enqueue and take.
    cyc(2'b11, mk(), mk(), 2'b00, 1'b0);
    cyc(2'b11, mk(), mk(), 2'b00, 1'b0);
    cyc(2'b11, mk(), mk(), 2'b11, 1'b1);
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_deq_valid", 128'(q.deq_valid), 128'(0));
    p = mk();
    cyc(2'b01, p, '0, 2'b00, 1'b0);
    chk("after_flush_P", 128'(q.deq_data[95:0]), 128'(p));
    idle();

    // Random traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      cyc(2'($urandom), {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
          2'($urandom), ($urandom_range(0, 31) == 0));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
